// File: rtl/spram_pkg.sv
// spram_pkg: shared widths, FSM states and request record for the SPRAM arbiter
package spram_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int ADDRESS_WIDTH = 30;
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} spram_arb_state_e;
  typedef struct packed {
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic                     owner;
  } spram_req_t;
endpackage

// File: rtl/spram_rr_arbiter.sv
// spram_rr_arbiter: 2-way grant; round-robin with SPRAM_ARB_RR_EN, fixed A-priority otherwise
module spram_rr_arbiter (
  input  logic a_valid,
  input  logic b_valid,
  input  logic last_grant,
  output logic grant_a,
  output logic grant_b
);
`ifndef SPRAM_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif
  // on a tie, round-robin favours whoever was not granted last (last_grant=1 means B)
  always_comb begin
`ifdef SPRAM_ARB_RR_EN
    grant_a = a_valid && (!b_valid || last_grant);
`else
    grant_a = a_valid;
`endif
    grant_b = b_valid && !grant_a;
  end
endmodule

// File: rtl/spram_arbiter.sv
// spram_arbiter: serialises two valid/ready requesters onto one single-port RAM (SPRAM_ARB_RR_EN selects round-robin)
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH    = spram_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = spram_pkg::ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_ready,
  output logic                     a_rsp_valid,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  input  logic                     b_valid,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_ready,
  output logic                     b_rsp_valid,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic                     mem_oe,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);
  spram_arb_state_e      state_q, state_d;
  spram_req_t            req_q, req_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  grant_a, grant_b;

  spram_rr_arbiter u_arb (
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .last_grant(last_grant_q),
    .grant_a   (grant_a),
    .grant_b   (grant_b)
  );

  // handshake, RAM drive, read return (live in RESP, held afterwards) and next-state logic
  always_comb begin
    a_ready      = rst_n && state_q == IDLE && grant_a;
    b_ready      = rst_n && state_q == IDLE && grant_b;
    a_rsp_valid  = state_q == RESP && req_q.owner == OWN_A;
    b_rsp_valid  = state_q == RESP && req_q.owner == OWN_B;
    a_rdata      = a_rsp_valid ? mem_rdata : a_rdata_q;
    b_rdata      = b_rsp_valid ? mem_rdata : b_rdata_q;
    mem_cs       = state_q == ACCESS;
    mem_we       = mem_cs && req_q.we;
    mem_oe       = mem_cs && !req_q.we;
    mem_addr     = req_q.addr;
    mem_wdata    = req_q.wdata;
    a_rdata_d    = a_rdata;
    b_rdata_d    = b_rdata;
    last_grant_d = b_ready ? OWN_B : a_ready ? OWN_A : last_grant_q;
    req_d        = b_ready ? spram_req_t'{we: b_we, addr: b_addr, wdata: b_wdata, owner: OWN_B} :
                   a_ready ? spram_req_t'{we: a_we, addr: a_addr, wdata: a_wdata, owner: OWN_A} : req_q;
    state_d      = state_q == IDLE   ? ((a_ready || b_ready) ? ACCESS : IDLE) :
                   state_q == ACCESS ? (req_q.we ? IDLE : RESP) : IDLE;
  end

  // state, request latch and held read data; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      last_grant_q <= OWN_B;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      last_grant_q <= last_grant_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end
endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed + random checks of spram_arbiter against a cycle-level model (honours SPRAM_ARB_RR_EN)
module tb_spram_arbiter;
  localparam int DW = 8;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ready, a_rsp_valid, b_ready, b_rsp_valid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic mem_cs, mem_we, mem_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ready(a_ready), .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ready(b_ready), .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM device: 256 words, addresses folded to {msb, low 7 bits}
  logic [DW-1:0] env_ram [0:255] = '{default: 8'h00};
  function automatic logic [7:0] idx(input logic [AW-1:0] a);
    return {a[AW-1], a[6:0]};
  endfunction
  initial forever begin
    @(posedge clk);
    if (mem_cs && mem_we) env_ram[idx(mem_addr)] <= mem_wdata;
    if (mem_cs && mem_oe) mem_rdata <= env_ram[idx(mem_addr)];
  end

  // reference model: grants from the tie rule, ops take 2 (write) or 3 (read) cycles
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int cyc = 0, next_free = 0, acc_cyc = -1, rsp_cyc = -1;
  logic m_last_b = 1'b1, m_we, m_rsp_b, free, tie, win_b, exp_a, exp_b, ea, eb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rsp_data, exp_a_rdata = '0, exp_b_rdata = '0;
  logic [2:0] exp_ctl;
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      next_free = cyc; acc_cyc = -1; rsp_cyc = -1; m_last_b = 1'b1;
      exp_a_rdata = '0; exp_b_rdata = '0;
    end else begin
      free = cyc >= next_free;
      tie = a_valid && b_valid;
`ifdef SPRAM_ARB_RR_EN
      win_b = tie ? !m_last_b : b_valid;
`else
      win_b = tie ? 1'b0 : b_valid;
`endif
      exp_b = free && win_b;
      exp_a = free && a_valid && !win_b;
      vectors++;
      if ({a_ready, b_ready} !== {exp_a, exp_b}) begin
        errors++;
        $display("FAIL ready cyc %0d: got a=%b b=%b expected a=%b b=%b", cyc, a_ready, b_ready, exp_a, exp_b);
      end
      exp_ctl = {cyc == acc_cyc, cyc == acc_cyc && m_we, cyc == acc_cyc && !m_we};
      vectors++;
      if ({mem_cs, mem_we, mem_oe} !== exp_ctl) begin
        errors++;
        $display("FAIL mem_ctl cyc %0d: got cs/we/oe=%b expected %b", cyc, {mem_cs, mem_we, mem_oe}, exp_ctl);
      end
      if (cyc == acc_cyc) begin
        vectors++;
        if ({mem_addr, mem_wdata} !== {m_addr, m_wdata}) begin
          errors++;
          $display("FAIL mem_bus cyc %0d: got addr=%h wdata=%h expected addr=%h wdata=%h", cyc, mem_addr, mem_wdata, m_addr, m_wdata);
        end
      end
      vectors++;
      if (mem_we && mem_oe) begin
        errors++;
        $display("FAIL we_oe_excl cyc %0d: got we=1 oe=1 expected not both", cyc);
      end
      ea = cyc == rsp_cyc && !m_rsp_b;
      eb = cyc == rsp_cyc && m_rsp_b;
      if (ea) exp_a_rdata = m_rsp_data;
      if (eb) exp_b_rdata = m_rsp_data;
      vectors++;
      if ({a_rsp_valid, b_rsp_valid} !== {ea, eb}) begin
        errors++;
        $display("FAIL rsp_valid cyc %0d: got a=%b b=%b expected a=%b b=%b", cyc, a_rsp_valid, b_rsp_valid, ea, eb);
      end
      vectors++;
      if ({a_rdata, b_rdata} !== {exp_a_rdata, exp_b_rdata}) begin
        errors++;
        $display("FAIL rdata cyc %0d: got a=%h b=%h expected a=%h b=%h", cyc, a_rdata, b_rdata, exp_a_rdata, exp_b_rdata);
      end
      if (exp_a || exp_b) begin
        m_last_b = exp_b;
        m_we = exp_b ? b_we : a_we;
        m_addr = exp_b ? b_addr : a_addr;
        m_wdata = exp_b ? b_wdata : a_wdata;
        acc_cyc = cyc + 1;
        if (m_we) begin
          ref_mem[m_addr] = m_wdata;
          next_free = cyc + 2;
        end else begin
          m_rsp_b = exp_b;
          m_rsp_data = ref_mem.exists(m_addr) ? ref_mem[m_addr] : 8'h00;
          rsp_cyc = cyc + 2;
          next_free = cyc + 3;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_valid = 1'b1; a_addr = 30'h5; b_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_cs, mem_we, mem_oe, mem_addr, a_rdata, b_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b cs/we/oe=%b%b%b addr=%h expected all zero", a_ready, b_ready, mem_cs, mem_we, mem_oe, mem_addr);
    end
    tick;
    a_valid = 1'b0; b_valid = 1'b0; rst_n = 1'b1;
    tick;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 30'h7;
    @(negedge clk);
    vectors++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_pre_accept: got %b expected 1", a_ready); end
    tick;
    a_valid = 1'b0;
    vectors++;
    if (mem_cs !== 1'b1) begin errors++; $display("FAIL reset_in_access: got cs=%b expected 1", mem_cs); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem_cs, mem_we, mem_oe} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async: got cs/we/oe=%b expected 000", {mem_cs, mem_we, mem_oe});
    end
    tick;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      vectors++;
      if ({a_rsp_valid, b_rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_rsp: got a=%b b=%b expected 0 0", a_rsp_valid, b_rsp_valid);
      end
    end
    tick;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 30'h20; b_wdata = 8'h3C;
    @(negedge clk);
    vectors++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_restart_ready: got %b expected 1", b_ready); end
    tick;
    b_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_cs, mem_we, mem_addr} !== {2'b11, 30'h20}) begin
      errors++;
      $display("FAIL reset_restart_access: got cs/we=%b%b addr=%h expected 11 00000020", mem_cs, mem_we, mem_addr);
    end
    tick;
  endtask

  task automatic test_write_read;
    a_valid = 1'b1; a_we = 1'b1; a_addr = 30'h10; a_wdata = 8'hA5;
    @(negedge clk);
    vectors++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", a_ready); end
    tick;
    a_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_cs, mem_we, mem_oe, mem_addr, mem_wdata} !== {3'b110, 30'h10, 8'hA5}) begin
      errors++;
      $display("FAIL wr_access: got cs/we/oe=%b%b%b addr=%h data=%h expected 110 00000010 a5", mem_cs, mem_we, mem_oe, mem_addr, mem_wdata);
    end
    tick;
    a_valid = 1'b1; a_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_we, a_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_pulse_end: got we=%b ready=%b expected we=0 ready=1", mem_we, a_ready);
    end
    tick;
    a_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_oe, a_rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL rd_access: got oe=%b rsp=%b expected oe=1 rsp=0", mem_oe, a_rsp_valid);
    end
    tick;
    @(negedge clk);
    vectors++;
    if ({a_rsp_valid, a_rdata} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL rd_rsp: got rsp=%b data=%h expected rsp=1 data=a5", a_rsp_valid, a_rdata);
    end
    tick;
    @(negedge clk);
    vectors++;
    if ({a_rsp_valid, a_rdata} !== {1'b0, 8'hA5}) begin
      errors++;
      $display("FAIL rd_hold: got rsp=%b data=%h expected rsp=0 data=a5", a_rsp_valid, a_rdata);
    end
    tick;
  endtask

  task automatic test_tie;
    int g = 0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 30'h1;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 30'h2;
    for (int c = 0; c < 40 && g < 6; c++) begin
      @(negedge clk);
`ifdef SPRAM_ARB_RR_EN
      if (a_ready || b_ready) begin
        vectors++;
        if ({a_ready, b_ready} !== {g % 2 == 0, g % 2 == 1}) begin
          errors++;
          $display("FAIL rr_order grant %0d: got a=%b b=%b expected a=%b b=%b", g, a_ready, b_ready, g % 2 == 0, g % 2 == 1);
        end
        g++;
      end
`else
      vectors++;
      if (b_ready !== 1'b0) begin errors++; $display("FAIL fixed_b_starve: got b_ready=%b expected 0", b_ready); end
      if (a_ready) g++;
`endif
      tick;
    end
    vectors++;
    if (g != 6) begin errors++; $display("FAIL tie_grants: got %0d grants expected 6", g); end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (4) tick;
  endtask

  task automatic test_max_addr;
    b_valid = 1'b1; b_we = 1'b1; b_addr = 30'h3FFF_FFFF; b_wdata = 8'hFF;
    @(negedge clk);
    vectors++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL max_ready: got %b expected 1", b_ready); end
    tick;
    b_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 30'h3FFF_FFFF, 8'hFF}) begin
      errors++;
      $display("FAIL max_addr: got we=%b addr=%h data=%h expected 1 3fffffff ff", mem_we, mem_addr, mem_wdata);
    end
    tick;
    b_valid = 1'b1; b_we = 1'b0;
    @(negedge clk);
    tick;
    b_valid = 1'b0;
    @(negedge clk);
    tick;
    @(negedge clk);
    vectors++;
    if ({b_rsp_valid, b_rdata} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL max_readback: got rsp=%b data=%h expected 1 ff", b_rsp_valid, b_rdata);
    end
    tick;
  endtask

  task automatic test_random;
    logic acc_a, acc_b;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      acc_a = a_ready; acc_b = b_ready;
      tick;
      if (!a_valid || acc_a) begin
        a_valid = $urandom_range(0, 2) != 0; a_we = $urandom_range(0, 1) == 1;
        a_addr = 30'($urandom_range(0, 127)); a_wdata = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) a_valid = 1'b0;
      if (!b_valid || acc_b) begin
        b_valid = $urandom_range(0, 2) != 0; b_we = $urandom_range(0, 1) == 1;
        b_addr = 30'($urandom_range(0, 127)); b_wdata = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) b_valid = 1'b0;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (5) tick;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_read;
    test_tie;
    test_max_addr;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
